// File: rtl/imem_loader.sv
// Program loader: assembles little-endian 32-bit words from a byte stream and
// writes them to instruction memory from address 0, stalling fetch meanwhile.
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              stall,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W:0]     wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          idx_q, idx_d;
  logic [31:0]         word_q, word_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_cnt_q <= '0;
      addr_q   <= '0;
      idx_q    <= '0;
      word_q   <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_cnt_q <= wr_cnt_d;
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_cnt_d = wr_cnt_q;
    addr_d   = addr_q;
    idx_d    = idx_q;
    word_d   = word_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d    = (word_count > DEPTH_C) ? DEPTH_C : word_count;
          wr_cnt_d = '0;
          addr_d   = '0;
          idx_d    = '0;
          word_d   = '0;
          state_d  = (word_count == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (byte_valid) begin
          word_d[{idx_q, 3'b000} +: 8] = byte_data;
          idx_d = idx_q + 2'd1;
          // The output registers capture the word directly so they hold
          // steady between writes while the next word assembles.
          if (idx_q == 2'd3) begin
            wdata_d = {byte_data, word_q[23:0]};
            waddr_d = addr_q;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        addr_d   = addr_q + 1'b1;
        wr_cnt_d = wr_cnt_q + 1'b1;
        if (abort)
          state_d = IDLE;
        else if (wr_cnt_d == cnt_q)
          state_d = DONE;
        else
          state_d = LOAD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign byte_ready = (state_q == LOAD) && !abort;
  assign imem_we    = (state_q == WRITE);
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign stall      = (state_q != IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: fixed byte streams with hand-computed
// instruction words, write addresses and done/stall timing.
module tb_imem_loader;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   word_count = '0;
  logic              abort = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready, imem_we, stall, busy, done;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int idle_cyc = 0;
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          done_cyc[$];
  logic [7:0]  stream[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
    .abort(abort), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .stall(stall), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write/done log; fetch must never see byte_ready during a write cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_we) begin
        wr_addr.push_back(int'(imem_addr));
        wr_data.push_back(imem_wdata);
        check_eq("ready_in_write", {31'd0, byte_ready}, 32'd0);
      end
      if (done) done_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_cyc.delete();
  endtask

  task automatic do_start(input int wc);
    start = 1'b1;
    word_count = wc[ADDR_W:0];
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives stream[] at negedges; optional one-cycle abort after abort_at accepts.
  task automatic feed(input bit gaps, input int abort_at, input int limit);
    int sent = 0;
    int n = 0;
    while (sent < stream.size() && n < limit) begin
      if (abort_at >= 0 && sent == abort_at) begin
        byte_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        return;
      end
      byte_valid = !(gaps && n[0]);
      byte_data  = stream[sent];
      #1;
      if (byte_valid && byte_ready) sent++;
      n++;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    if (n >= limit) check_eq("feed_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (stall && n < limit) begin
      @(negedge clk);
      n++;
    end
    idle_cyc = cyc;
    if (n >= limit) check_eq("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_we"},    {31'd0, imem_we}, 32'd0);
    check_eq({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
    check_eq({tag, "_stall"}, {31'd0, stall}, 32'd0);
    check_eq({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check_eq({tag, "_done"},  {31'd0, done}, 32'd0);
    check_eq({tag, "_addr"},  32'(imem_addr), 32'd0);
    check_eq({tag, "_wdata"}, imem_wdata, 32'd0);
  endtask

  task automatic load_two_word_stream();
    stream.delete();
    stream = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  endtask

  function automatic logic [7:0] gen_byte(input int w, input int k);
    return 8'(((w * 4 + k) * 7) + 3);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    @(negedge clk);
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-word load, continuous stream
    load_two_word_stream();
    clear_log();
    do_start(2);
    check_eq("t1_stall_rise", {31'd0, stall}, 32'd1);
    check_eq("t1_busy_rise",  {31'd0, busy}, 32'd1);
    check_eq("t1_ready_rise", {31'd0, byte_ready}, 32'd1);
    feed(1'b0, -1, 200);
    wait_idle(50);
    check_eq("t1_nwrites", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check_eq("t1_addr0", wr_addr[0], 0);
      check_eq("t1_data0", wr_data[0], 32'h12345678);
      check_eq("t1_addr1", wr_addr[1], 1);
      check_eq("t1_data1", wr_data[1], 32'hDEADBEEF);
    end
    check_eq("t1_ndone", done_cyc.size(), 1);
    if (done_cyc.size() == 1) check_eq("t1_done_time", done_cyc[0] - start_cyc, 11);
    check_eq("t1_stall_fall", idle_cyc - start_cyc, 12);

    // Backpressure: byte_valid low every other cycle
    load_two_word_stream();
    @(negedge clk);
    clear_log();
    do_start(2);
    feed(1'b1, -1, 200);
    wait_idle(50);
    check_eq("t2_nwrites", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check_eq("t2_addr0", wr_addr[0], 0);
      check_eq("t2_data0", wr_data[0], 32'h12345678);
      check_eq("t2_addr1", wr_addr[1], 1);
      check_eq("t2_data1", wr_data[1], 32'hDEADBEEF);
    end
    check_eq("t2_ndone", done_cyc.size(), 1);

    // word_count = 0
    @(negedge clk);
    clear_log();
    do_start(0);
    check_eq("t3_done_now", {31'd0, done}, 32'd1);
    check_eq("t3_stall", {31'd0, stall}, 32'd1);
    wait_idle(20);
    check_eq("t3_nwrites", wr_addr.size(), 0);
    check_eq("t3_ndone", done_cyc.size(), 1);

    // word_count = 100 clamps to 64
    stream.delete();
    for (int w = 0; w < 64; w++)
      for (int k = 0; k < 4; k++) stream.push_back(gen_byte(w, k));
    @(negedge clk);
    clear_log();
    do_start(100);
    feed(1'b0, -1, 2000);
    wait_idle(50);
    check_eq("t4_nwrites", wr_addr.size(), 64);
    if (wr_addr.size() == 64) begin
      for (int w = 0; w < 64; w++) begin
        check_eq($sformatf("t4_addr%0d", w), wr_addr[w], w);
        check_eq($sformatf("t4_data%0d", w), wr_data[w],
                 {gen_byte(w, 3), gen_byte(w, 2), gen_byte(w, 1), gen_byte(w, 0)});
      end
    end
    check_eq("t4_ndone", done_cyc.size(), 1);

    // Abort after 2 bytes of word 1 of a 3-word load
    stream.delete();
    for (int i = 1; i <= 12; i++) stream.push_back(8'(i));
    @(negedge clk);
    clear_log();
    do_start(3);
    feed(1'b0, 6, 200);
    check_eq("t5_stall_drop", {31'd0, stall}, 32'd0);
    repeat (3) @(negedge clk);
    check_eq("t5_nwrites", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check_eq("t5_addr0", wr_addr[0], 0);
      check_eq("t5_data0", wr_data[0], 32'h04030201);
    end
    check_eq("t5_ndone", done_cyc.size(), 0);
    stream.delete();
    stream = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    clear_log();
    do_start(1);
    feed(1'b0, -1, 200);
    wait_idle(50);
    check_eq("t5r_nwrites", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check_eq("t5r_addr0", wr_addr[0], 0);
      check_eq("t5r_data0", wr_data[0], 32'hDDCCBBAA);
    end
    check_eq("t5r_ndone", done_cyc.size(), 1);

    // Reset during the WRITE of word 1
    load_two_word_stream();
    @(negedge clk);
    clear_log();
    do_start(2);
    feed(1'b0, -1, 200);
    check_eq("t6_in_write", {31'd0, imem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("t6_rst");
    start = 1'b1;
    word_count = 7'd3;
    repeat (2) @(negedge clk);
    check_eq("t6_start_ignored", {31'd0, stall}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    clear_log();
    @(negedge clk);
    check_eq("t6_idle_after", {31'd0, stall}, 32'd0);
    stream.delete();
    stream = '{8'h44, 8'h33, 8'h22, 8'h11};
    do_start(1);
    feed(1'b0, -1, 200);
    wait_idle(50);
    check_eq("t6_nwrites", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check_eq("t6_addr0", wr_addr[0], 0);
      check_eq("t6_data0", wr_data[0], 32'h11223344);
    end
    check_eq("t6_ndone", done_cyc.size(), 1);
    if (done_cyc.size() == 1) check_eq("t6_done_time", done_cyc[0] - start_cyc, 6);

    // start with a different word_count mid-load is ignored
    load_two_word_stream();
    @(negedge clk);
    clear_log();
    do_start(2);
    fork
      feed(1'b0, -1, 200);
      begin
        repeat (3) @(negedge clk);
        start = 1'b1;
        word_count = 7'd5;
        @(negedge clk);
        start = 1'b0;
      end
    join
    wait_idle(50);
    repeat (8) @(negedge clk);
    check_eq("t7_nwrites", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check_eq("t7_addr1", wr_addr[1], 1);
      check_eq("t7_data1", wr_data[1], 32'hDEADBEEF);
    end
    check_eq("t7_ndone", done_cyc.size(), 1);
    if (done_cyc.size() == 1) check_eq("t7_done_time", done_cyc[0] - start_cyc, 11);
    check_eq("t7_idle", {31'd0, stall}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
